reorder_id_allocator: RTL and testbench



---
 rtl/reorder_id_allocator_if.sv | 26 ++
 rtl/reorder_id_allocator.sv | 102 ++++++++++
 tb/tb_reorder_id_allocator.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/reorder_id_allocator_if.sv
// Handshake bundle between dispatch/commit side (master) and the ID allocator (slave).
interface reorder_id_allocator_if #(
  parameter int DEPTH = 64
);
  localparam int ID_WIDTH = $clog2(DEPTH);

  logic                alloc_req_i;
  logic                alloc_gnt_o;
  logic [ID_WIDTH-1:0] alloc_id_o;
  logic                commit_id_valid_i;
  logic [ID_WIDTH-1:0] commit_id_value_i;
  logic                commit_id_pull_o;
  logic [ID_WIDTH:0]   free_count_o;
  logic                init_done_o;
  logic                error_o;

  modport master (
    output alloc_req_i, commit_id_valid_i, commit_id_value_i,
    input  alloc_gnt_o, alloc_id_o, commit_id_pull_o, free_count_o, init_done_o, error_o
  );

  modport slave (
    input  alloc_req_i, commit_id_valid_i, commit_id_value_i,
    output alloc_gnt_o, alloc_id_o, commit_id_pull_o, free_count_o, init_done_o, error_o
  );
endinterface

// File: rtl/reorder_id_allocator.sv
// Free-list ID allocator: builds list 0..DEPTH-1 in INIT, then grants IDs and recycles committed ones in FIFO order.
// Grant and commit pull are combinational (0 cycles); no grant when empty, no pull when full, double free sets error_o.
module reorder_id_allocator #(
  parameter int DEPTH = 64
) (
  input logic                   clk_i,
  input logic                   rst_i,
  reorder_id_allocator_if.slave bus
);
  localparam int ID_WIDTH = $clog2(DEPTH);
  localparam logic [ID_WIDTH:0]   FULL_CNT = (ID_WIDTH+1)'(DEPTH);
  localparam logic [ID_WIDTH-1:0] LAST_ID  = ID_WIDTH'(DEPTH-1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] mem [DEPTH];
  logic [ID_WIDTH-1:0] rd_ptr;
  logic [ID_WIDTH-1:0] wr_ptr;
  logic [ID_WIDTH-1:0] init_cnt;
  logic [ID_WIDTH:0]   count;
  logic [DEPTH-1:0]    live;
  logic                init_done;
  logic                error;

  logic                run;
  logic                gnt;
  logic                pull;
  logic                free_ok;
  logic                mem_we;
  logic [ID_WIDTH-1:0] gnt_id;
  logic [ID_WIDTH-1:0] mem_wdat;

  // Grant and pull each depend only on state and their own side's inputs.
  always_comb begin
    run      = (state == ST_RUN);
    gnt      = run & bus.alloc_req_i & (count != '0);
    gnt_id   = gnt ? mem[rd_ptr] : '0;
    pull     = run & bus.commit_id_valid_i & (count != FULL_CNT);
    free_ok  = pull & live[bus.commit_id_value_i];
    mem_we   = ~rst_i & (run ? free_ok : 1'b1);
    mem_wdat = run ? bus.commit_id_value_i : init_cnt;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[wr_ptr] <= mem_wdat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_INIT;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      init_cnt  <= '0;
      count     <= '0;
      live      <= '0;
      init_done <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          wr_ptr   <= wr_ptr + 1'b1;
          count    <= count + 1'b1;
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_ID) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (gnt) begin
            rd_ptr       <= rd_ptr + 1'b1;
            live[gnt_id] <= 1'b1;
          end
          if (free_ok) begin
            wr_ptr                        <= wr_ptr + 1'b1;
            live[bus.commit_id_value_i]   <= 1'b0;
          end
          if (pull && !free_ok) begin
            error <= 1'b1;
          end
          // A grant and an accepted free in the same cycle cancel out.
          if (gnt && !free_ok) begin
            count <= count - 1'b1;
          end else if (!gnt && free_ok) begin
            count <= count + 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus.alloc_gnt_o      = gnt;
  assign bus.alloc_id_o       = gnt_id;
  assign bus.commit_id_pull_o = pull;
  assign bus.free_count_o     = count;
  assign bus.init_done_o      = init_done;
  assign bus.error_o          = error;
endmodule

// File: tb/tb_reorder_id_allocator.sv
// Scoreboard bench for reorder_id_allocator: expected free-list order is queued as IDs are freed and popped on each grant.
module tb_reorder_id_allocator;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reorder_id_allocator_if #(.DEPTH(DEPTH)) bus();
  reorder_id_allocator #(.DEPTH(DEPTH)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  int sb[$];
  bit mlive[DEPTH];
  int mcount;
  bit merr;

  logic       s_gnt, s_pull, s_done, s_err;
  logic [5:0] s_id;
  logic [6:0] s_cnt;

  logic e_gnt, e_pull;
  int   e_id;

  task automatic run_cycle(input logic req, input logic cv, input logic [5:0] val);
    bus.alloc_req_i       = req;
    bus.commit_id_valid_i = cv;
    bus.commit_id_value_i = val;
    #1;
    s_gnt  = bus.alloc_gnt_o;
    s_id   = bus.alloc_id_o;
    s_pull = bus.commit_id_pull_o;
    @(posedge clk);
    #1;
    s_cnt  = bus.free_count_o;
    s_done = bus.init_done_o;
    s_err  = bus.error_o;
    @(negedge clk);
  endtask

  // Predicts the cycle's handshakes from the model, drives it, then advances the model.
  task automatic do_cycle(input logic req, input logic cv, input logic [5:0] val);
    e_gnt  = req && (mcount != 0);
    e_pull = cv && (mcount != DEPTH);
    e_id   = 0;
    if (e_gnt) e_id = sb.pop_front();
    run_cycle(req, cv, val);
    if (e_pull) begin
      if (mlive[val]) begin
        sb.push_back(int'(val));
        mlive[val] = 1'b0;
      end else begin
        merr = 1'b1;
      end
    end
    if (e_gnt) mlive[e_id] = 1'b1;
    mcount = sb.size();
  endtask

  task automatic test_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) run_cycle(1'b1, 1'b1, 6'd0);
    #1;
    checks++; if (bus.alloc_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt got %0b want 0", bus.alloc_gnt_o); end
    checks++; if (bus.alloc_id_o !== 6'd0) begin errors++; $display("FAIL reset_id got %0d want 0", bus.alloc_id_o); end
    checks++; if (bus.commit_id_pull_o !== 1'b0) begin errors++; $display("FAIL reset_pull got %0b want 0", bus.commit_id_pull_o); end
    checks++; if (s_cnt !== 7'd0) begin errors++; $display("FAIL reset_count got %0d want 0", s_cnt); end
    checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", s_done); end
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", s_err); end
    sb.delete();
    foreach (mlive[i]) mlive[i] = 1'b0;
    merr   = 1'b0;
    mcount = 0;
  endtask

  task automatic test_init();
    int n;
    bit done;
    rst  = 1'b0;
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      run_cycle(1'b1, 1'b1, 6'(n));
      n++;
      checks++;
      if ({s_gnt, s_pull} !== 2'b00) begin
        errors++; $display("FAIL init_handshake cycle %0d got gnt/pull %0b%0b want 00", n, s_gnt, s_pull);
      end
      done = (s_done === 1'b1);
    end
    checks++; if (n !== 64) begin errors++; $display("FAIL init_cycles got %0d want 64", n); end
    checks++; if (s_cnt !== 7'd64) begin errors++; $display("FAIL init_count got %0d want 64", s_cnt); end
    for (int i = 0; i < DEPTH; i++) sb.push_back(i);
    mcount = DEPTH;
  endtask

  task automatic test_drain(input int n);
    for (int i = 0; i < n; i++) begin
      do_cycle(1'b1, 1'b0, 6'd0);
      checks++; if (s_gnt !== e_gnt) begin errors++; $display("FAIL drain_gnt cycle %0d got %0b want %0b", i, s_gnt, e_gnt); end
      checks++; if (s_id !== 6'(e_id)) begin errors++; $display("FAIL drain_id cycle %0d got %0d want %0d", i, s_id, e_id); end
      checks++; if (s_cnt !== 7'(mcount)) begin errors++; $display("FAIL drain_count cycle %0d got %0d want %0d", i, s_cnt, mcount); end
      checks++; if (s_err !== merr) begin errors++; $display("FAIL drain_err cycle %0d got %0b want %0b", i, s_err, merr); end
    end
  endtask

  task automatic test_recycle();
    logic       req_t [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic       cv_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [5:0] val_t [4] = '{6'd5, 6'd17, 6'd0, 6'd0};
    logic [6:0] cnt_t [4] = '{7'd1, 7'd2, 7'd1, 7'd0};
    for (int i = 0; i < 4; i++) begin
      do_cycle(req_t[i], cv_t[i], val_t[i]);
      checks++; if (s_gnt !== e_gnt) begin errors++; $display("FAIL recycle_gnt step %0d got %0b want %0b", i, s_gnt, e_gnt); end
      checks++; if (s_id !== 6'(e_id)) begin errors++; $display("FAIL recycle_id step %0d got %0d want %0d", i, s_id, e_id); end
      checks++; if (s_pull !== e_pull) begin errors++; $display("FAIL recycle_pull step %0d got %0b want %0b", i, s_pull, e_pull); end
      checks++; if (s_cnt !== cnt_t[i]) begin errors++; $display("FAIL recycle_count step %0d got %0d want %0d", i, s_cnt, cnt_t[i]); end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b1, 6'(20 + i));
    checks++; if (s_cnt !== 7'd10) begin errors++; $display("FAIL simul_setup_count got %0d want 10", s_cnt); end
    do_cycle(1'b1, 1'b1, 6'd3);
    checks++; if ({s_gnt, s_pull} !== 2'b11) begin errors++; $display("FAIL simul_handshake got %0b%0b want 11", s_gnt, s_pull); end
    checks++; if (s_id !== 6'(e_id)) begin errors++; $display("FAIL simul_id got %0d want %0d", s_id, e_id); end
    checks++; if (s_cnt !== 7'd10) begin errors++; $display("FAIL simul_count got %0d want 10", s_cnt); end
    checks++; if (sb[$] !== 3) begin errors++; $display("FAIL simul_tail got %0d want 3", sb[$]); end
    test_drain(11);
  endtask

  task automatic test_double_free();
    do_cycle(1'b0, 1'b1, 6'd7);
    checks++; if (s_pull !== 1'b1) begin errors++; $display("FAIL dfree_pull1 got %0b want 1", s_pull); end
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL dfree_err1 got %0b want 0", s_err); end
    do_cycle(1'b0, 1'b1, 6'd7);
    checks++; if (s_pull !== 1'b1) begin errors++; $display("FAIL dfree_pull2 got %0b want 1", s_pull); end
    checks++; if (s_cnt !== 7'd1) begin errors++; $display("FAIL dfree_count got %0d want 1", s_cnt); end
    checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL dfree_err2 got %0b want 1", s_err); end
    do_cycle(1'b0, 1'b0, 6'd0);
    checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL dfree_sticky got %0b want 1", s_err); end
    test_drain(2);
  endtask

  task automatic test_midrun_reset();
    for (int i = 0; i < 34; i++) do_cycle(1'b0, 1'b1, 6'(30 + i));
    checks++; if (s_cnt !== 7'd34) begin errors++; $display("FAIL midrst_setup_count got %0d want 34", s_cnt); end
    test_reset(1);
    test_init();
    test_drain(DEPTH);
  endtask

  initial begin
    bus.alloc_req_i       = 1'b0;
    bus.commit_id_valid_i = 1'b0;
    bus.commit_id_value_i = 6'd0;
    mcount = 0;
    merr   = 1'b0;
    test_reset(2);
    test_init();
    test_drain(66);
    test_recycle();
    test_simultaneous();
    test_double_free();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
